// File: rtl/uart_loader.sv
// Serial boot loader: receives an 8N1 framed program image and writes big-endian
// 16-bit words sequentially into program RAM while holding the CPU in reset.
module uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned MEM_SIZE     = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic        o_ce,
    output logic        o_we,
    output logic [15:0] o_addr,
    output logic [15:0] o_w_data,
    output logic        o_cpu_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullCnt = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [3:0] {
        LdIdle, LdCntHi, LdCntLo, LdDataHi, LdDataLo, LdWrite, LdChk, LdDone, LdErr
    } ld_state_e;

    rx_state_e   rx_st;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        byte_valid, frame_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_st      <= RxIdle;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= i_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_st)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        rx_st   <= RxStart;
                        clk_cnt <= '0;
                    end
                end
                RxStart: begin
                    // Mid-start-bit recheck rejects short glitches
                    if (clk_cnt == HalfCnt) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx_sync ? RxIdle : RxData;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (clk_cnt == FullCnt) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_st <= RxStop;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    if (clk_cnt == FullCnt) begin
                        clk_cnt <= '0;
                        rx_st   <= RxIdle;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: rx_st <= RxIdle;
            endcase
        end
    end

    ld_state_e   ld_st;
    logic [7:0]  count_hi, data_hi, acc;
    logic [15:0] word_cnt, word_idx;
    logic [15:0] count_n;

    assign count_n = {count_hi, rx_shift};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ld_st     <= LdIdle;
            count_hi  <= '0;
            data_hi   <= '0;
            acc       <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            o_ce      <= 1'b0;
            o_we      <= 1'b0;
            o_addr    <= '0;
            o_w_data  <= '0;
            o_cpu_rst <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_ce <= 1'b0;
            o_we <= 1'b0;
            // o_busy is high exactly while a frame is in progress
            if (frame_err && o_busy) begin
                ld_st  <= LdErr;
                o_err  <= 1'b1;
                o_busy <= 1'b0;
            end else begin
                case (ld_st)
                    LdIdle, LdDone, LdErr: begin
                        if (byte_valid && rx_shift == 8'hA5) begin
                            ld_st     <= LdCntHi;
                            o_busy    <= 1'b1;
                            o_cpu_rst <= 1'b1;
                            o_done    <= 1'b0;
                            o_err     <= 1'b0;
                            word_idx  <= '0;
                            acc       <= '0;
                        end
                    end
                    LdCntHi: begin
                        if (byte_valid) begin
                            count_hi <= rx_shift;
                            ld_st    <= LdCntLo;
                        end
                    end
                    LdCntLo: begin
                        if (byte_valid) begin
                            word_cnt <= count_n;
                            if (32'(count_n) > MEM_SIZE) begin
                                ld_st  <= LdErr;
                                o_err  <= 1'b1;
                                o_busy <= 1'b0;
                            end else if (count_n == 16'd0) begin
                                ld_st <= LdChk;
                            end else begin
                                ld_st <= LdDataHi;
                            end
                        end
                    end
                    LdDataHi: begin
                        if (byte_valid) begin
                            data_hi <= rx_shift;
                            acc     <= acc ^ rx_shift;
                            ld_st   <= LdDataLo;
                        end
                    end
                    LdDataLo: begin
                        if (byte_valid) begin
                            acc      <= acc ^ rx_shift;
                            o_ce     <= 1'b1;
                            o_we     <= 1'b1;
                            o_addr   <= 16'(BASE_ADDR) + word_idx;
                            o_w_data <= {data_hi, rx_shift};
                            ld_st    <= LdWrite;
                        end
                    end
                    LdWrite: begin
                        word_idx <= word_idx + 16'd1;
                        ld_st    <= (word_idx + 16'd1 == word_cnt) ? LdChk : LdDataHi;
                    end
                    LdChk: begin
                        if (byte_valid) begin
                            o_busy <= 1'b0;
                            if (rx_shift == acc) begin
                                ld_st     <= LdDone;
                                o_done    <= 1'b1;
                                o_cpu_rst <= 1'b0;
                            end else begin
                                ld_st <= LdErr;
                                o_err <= 1'b1;
                            end
                        end
                    end
                    default: ld_st <= LdIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised bench for uart_loader: a byte-level frame model predicts RAM writes
// and status; a per-cycle monitor checks the RAM port against it.
module tb_uart_loader;

    localparam int unsigned Cpb     = 8;
    localparam int unsigned MemSize = 1024;
    localparam int          MinGap  = 2 * 10 * Cpb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        ce, we, cpu_rst, busy, done, err;
    logic [15:0] addr, w_data;

    uart_loader #(
        .CLKS_PER_BIT(Cpb),
        .BASE_ADDR   (0),
        .MEM_SIZE    (MemSize)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_rx     (rx),
        .o_ce     (ce),
        .o_we     (we),
        .o_addr   (addr),
        .o_w_data (w_data),
        .o_cpu_rst(cpu_rst),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] last_addr = '0, last_data = '0;
    logic [15:0] ram [16];
    int          last_wr_cyc = 0;
    bit          have_wr = 0;
    logic [7:0]  tx_q[$];

    // Frame model state
    int          m_phase = 0;  // 0 waiting for sync, 1 cnt_hi, 2 cnt_lo, 3 data, 4 checksum
    logic [7:0]  m_nhi, m_hi, m_acc;
    int          m_n, m_idx;
    bit          m_have_hi;
    logic        m_busy = 0, m_done = 0, m_err = 0, m_cpu = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            if (m_phase != 0) begin
                m_err = 1; m_busy = 0; m_phase = 0;
            end
            return;
        end
        case (m_phase)
            0: if (b == 8'hA5) begin
                m_phase = 1; m_busy = 1; m_cpu = 1; m_done = 0; m_err = 0;
                m_idx = 0; m_acc = 0;
            end
            1: begin m_nhi = b; m_phase = 2; end
            2: begin
                m_n = int'({m_nhi, b});
                if (m_n > int'(MemSize)) begin
                    m_err = 1; m_busy = 0; m_phase = 0;
                end else begin
                    m_phase = (m_n == 0) ? 4 : 3;
                    m_have_hi = 0;
                end
            end
            3: begin
                m_acc ^= b;
                if (!m_have_hi) begin
                    m_hi = b; m_have_hi = 1;
                end else begin
                    exp_q.push_back('{a: 16'(m_idx), d: {m_hi, b}});
                    m_idx++; m_have_hi = 0;
                    if (m_idx == m_n) m_phase = 4;
                end
            end
            default: begin
                m_busy = 0; m_phase = 0;
                if (b == m_acc) begin m_done = 1; m_cpu = 0; end
                else m_err = 1;
            end
        endcase
    endtask

    task automatic chk_status(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(m_cpu));
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (Cpb) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        model_byte(b, good);
        @(posedge clk); #1;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(good);
        bit_time(1'b1);
        chk_status("byte");
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        m_phase = 0; m_busy = 0; m_done = 0; m_err = 0; m_cpu = 0;
        last_addr = '0; last_data = '0; have_wr = 0;
        exp_q.delete();
        rx = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Port monitor: every write must be predicted, single-cycle, spaced, and held afterwards
    always @(negedge clk) begin
        check("we_eq_ce", 32'(we), 32'(ce));
        if (ce) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(addr), 32'(w.a));
                check("wr_data", 32'(w_data), 32'(w.d));
                last_addr = w.a;
                last_data = w.d;
            end
            if (have_wr && (cyc - last_wr_cyc) < MinGap)
                check("write_gap", 32'(cyc - last_wr_cyc), 32'(MinGap));
            last_wr_cyc = cyc;
            have_wr = 1;
            if (addr < 16'd16) ram[addr[3:0]] = w_data;
        end else begin
            check("addr_hold", 32'(addr), 32'(last_addr));
            check("data_hold", 32'(w_data), 32'(last_data));
        end
    end

    initial begin
        logic [7:0] c, d;
        int n;
        for (int i = 0; i < 16; i++) ram[i] = '0;

        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ce", 32'(ce), 32'd0);
        check("rst.addr", 32'(addr), 32'd0);
        check("rst.wdata", 32'(w_data), 32'd0);
        check("rst.cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        rst = 0;
        repeat (4) @(posedge clk);

        // Basic two-word frame
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_q();
        check("f1.done", 32'(done), 32'd1);
        check("f1.cpu_rst", 32'(cpu_rst), 32'd0);
        check("f1.ram0", 32'(ram[0]), 32'h1234);
        check("f1.ram1", 32'(ram[1]), 32'hABCD);

        // Bad checksum, then recovery
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_q();
        check("f2.err", 32'(err), 32'd1);
        check("f2.cpu_rst", 32'(cpu_rst), 32'd1);
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_q();
        check("f3.done", 32'(done), 32'd1);
        check("f3.err", 32'(err), 32'd0);

        // Oversized count
        tx_q = '{8'hA5, 8'h04, 8'h01};
        send_q();
        check("f4.err", 32'(err), 32'd1);
        check("f4.busy", 32'(busy), 32'd0);

        // Noise then empty frame
        tx_q = '{8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        check("f5.done", 32'(done), 32'd1);

        // Framing error on second data byte
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_q();
        send_byte(8'h34, 1'b0);
        check("f6.err", 32'(err), 32'd1);
        check("f6.pending", 32'(exp_q.size()), 32'd0);

        // Short glitch between bytes must not produce a byte
        tx_q = '{8'hA5, 8'h00, 8'h01};
        send_q();
        @(posedge clk); #1 rx = 0;
        repeat (2) @(posedge clk);
        #1 rx = 1;
        repeat (3 * 10 * Cpb) @(posedge clk);
        #1;
        chk_status("glitch");
        tx_q = '{8'h77, 8'h88, 8'hFF};
        send_q();
        check("f7.done", 32'(done), 32'd1);
        check("f7.ram0", 32'(ram[0]), 32'h7788);

        // Reset in the middle of the second word
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_q();
        do_reset();
        chk_status("midrst");
        check("midrst.addr", 32'(addr), 32'd0);
        check("midrst.ram0", 32'(ram[0]), 32'h1234);
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBE, 8'hEF, 8'h65};
        send_q();
        check("f8.done", 32'(done), 32'd1);
        check("f8.ram0", 32'(ram[0]), 32'hCAFE);
        check("f8.ram1", 32'(ram[1]), 32'hBEEF);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = 8'($urandom);
                if (c == 8'hA5) c = 8'h3C;
                tx_q.push_back(c);
            end
            n = $urandom_range(0, 3);
            tx_q.push_back(8'hA5);
            tx_q.push_back(8'h00);
            tx_q.push_back(8'(n));
            c = '0;
            for (int i = 0; i < 2 * n; i++) begin
                d = 8'($urandom);
                c ^= d;
                tx_q.push_back(d);
            end
            if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
            tx_q.push_back(c);
            send_q();
        end

        repeat (20) @(posedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial boot loader that sits directly upstream of the 16-bit program RAM. It receives a framed program image over an 8N1 UART line, assembles big-endian 16-bit words and writes them sequentially into the RAM through its chip-enable/write-enable port. It holds the CPU in reset while loading and reports completion or error. The RAM's address window and size are mirrored as parameters so the loader never writes outside the array.

## Interface
- CLKS_PER_BIT, 104: i_clk cycles per UART bit; must be ≥ 4.
- BASE_ADDR, 0: RAM address of the first loaded word.
- MEM_SIZE, 1024: RAM depth in words; the largest accepted word count is MEM_SIZE.

- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx  in  1  UART receive line, idle high, asynchronous to i_clk.
- o_ce  out  1  RAM chip enable; high only during a write pulse.
- o_we  out  1  RAM write enable; identical to o_ce.
- o_addr  out  16  RAM word address.
- o_w_data  out  16  RAM write data.
- o_cpu_rst  out  1  holds the CPU in reset while high.
- o_busy  out  1  high while a frame is in progress.
- o_done  out  1  high after a frame loads with a good checksum.
- o_err  out  1  high after a framing, length or checksum error.

## Operation
- Frame format: sync byte 0xA5, count_hi, count_lo, then 2·N data bytes (high byte of each word first), then a checksum byte equal to the XOR of all 2·N data bytes. N = {count_hi, count_lo}.
- Receiver:
  - i_rx passes through a 2-flop synchronizer.
  - A falling edge while idle starts a bit timer. The line is rechecked at CLKS_PER_BIT/2; if it is high, the start is false and the receiver returns to idle.
  - 8 data bits are then sampled LSB first at CLKS_PER_BIT intervals, followed by the stop bit.
  - A low stop bit is a framing error.
  - A good byte produces a one-cycle internal byte_valid.
- Loader FSM states: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR.
  - IDLE/DONE/ERR: byte 0xA5 → CNT_HI. In the same cycle: o_busy=1, o_cpu_rst=1, o_done=0, o_err=0, word index=0, XOR accumulator=0. Any other byte is ignored.
  - CNT_HI → CNT_LO → if N > MEM_SIZE, go to ERR with no writes. If N = 0, go to CHK. Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, then go to DATA_LO. DATA_LO: latch the low byte, then go to WRITE. Each data byte is XORed into the accumulator.
  - WRITE lasts one cycle: o_ce=o_we=1, o_addr=BASE_ADDR+index, o_w_data={hi,lo}. Then index increments; if index = N, go to CHK, otherwise go to DATA_HI.
  - CHK: if the checksum byte equals the accumulator → DONE (o_done=1, o_busy=0, o_cpu_rst=0). Otherwise → ERR.
  - ERR: o_err=1, o_busy=0, o_cpu_rst stays 1.
  - A framing error in any non-idle state → ERR.
- Address and index arithmetic is 16 bits, unsigned, and never wraps, because N ≤ MEM_SIZE.
- A new 0xA5 received in DONE or ERR restarts loading. 0xA5 bytes received inside a frame are treated as data.

## Timing
- Reset values: all outputs 0, FSM=IDLE, receiver idle. A reset mid-frame abandons the frame; words already written stay in RAM.
- Byte latency: byte_valid occurs 2 cycles (synchronizer) plus about 9.5·CLKS_PER_BIT cycles after the start-bit falling edge.
- The write pulse occurs in the cycle immediately after the low byte's byte_valid.
- o_addr and o_w_data are held from the write pulse until the next write; there are no glitches while o_ce=0.
- o_done, o_err and o_cpu_rst change in the cycle after the byte_valid that decides them.
- The loader never issues two writes closer together than 2·10·CLKS_PER_BIT cycles.

## Test plan
- CLKS_PER_BIT=8. Send A5 00 02 12 34 AB CD 40 → writes 0x1234@0 and 0xABCD@1, one cycle each; then o_done=1, o_cpu_rst=0, o_err=0.
- Same frame with checksum 41 → both writes occur, then o_err=1 and o_cpu_rst stays 1. Resending the correct frame clears o_err and sets o_done.
- A5 04 01 (N=1025 > 1024) → no writes, o_err=1 right after count_lo.
- A5 00 00 00 → no writes, o_done=1. A noise byte 0x3C before the sync is ignored.
- Stop bit driven low during the second data byte → ERR, no write. A 0.3-bit low glitch on i_rx while idle causes no byte_valid.
- Assert i_rst during DATA_LO of the second word → all outputs 0, FSM=IDLE, word 0 remains in RAM; a following full frame loads correctly.
